// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised, oversampled UART receiver.
// The line is sampled OVERSAMPLE times per bit. The three samples around
// mid-bit are combined by a 2-of-3 majority vote to give each bit value.
// The receiver checks parity and stop bits, reports overruns, and hands
// each frame to the consumer through a valid/ready pair.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx         serial line, idle high, asynchronous to clk
//   rx_data    received word, LSB = first data bit on the line
//   rx_valid   rx_data and the error flags hold an unconsumed frame
//   rx_ready   consumer accepts the frame when high with rx_valid
//   parity_err parity mismatch for the frame in rx_data
//   frame_err  a stop bit was sampled low for the frame in rx_data
//   overrun    1-cycle pulse when an unconsumed frame is overwritten
//   busy       high from an accepted start bit until the return to idle
module uart_rx_param #(
  parameter int CLK_FREQ   = 65_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int MID = OVERSAMPLE / 2;

  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0] SC_S0   = SCW'(MID - 1);
  localparam logic [SCW-1:0] SC_S1   = SCW'(MID);
  localparam logic [SCW-1:0] SC_S2   = SCW'(MID + 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_rx_param: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Two-flop synchroniser, reset to the idle line level.
  logic sync1_q, rxs_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

  // Free-running oversample tick generator.
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  state_t               state_q;
  logic [SCW-1:0]       sc_q;
  logic [BW-1:0]        bit_idx_q;
  logic                 stop_idx_q;
  logic                 s0_q, s1_q;
  logic                 armed_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 pe_pend_q, fe_pend_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, parity_err_q, frame_err_q, overrun_q, busy_q;

  // The third sample is the live synchronised value on the vote tick.
  logic maj, vote_done, sc_end, par_bad;
  always_comb begin
    maj       = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
    vote_done = (sc_q == SC_S2);
    sc_end    = (sc_q == SC_LAST);
    par_bad   = (^shreg_q ^ maj) ^ (PARITY == 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sc_q         <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      s0_q         <= 1'b0;
      s1_q         <= 1'b0;
      armed_q      <= 1'b0;
      shreg_q      <= '0;
      pe_pend_q    <= 1'b0;
      fe_pend_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      if (tick) begin
        if (rxs_q) armed_q <= 1'b1;

        if (state_q == S_IDLE) begin
          if (armed_q && !rxs_q) begin
            // This tick is sample 0 of the start bit, so the next one is 1.
            state_q   <= S_START;
            sc_q      <= SCW'(1);
            busy_q    <= 1'b1;
            pe_pend_q <= 1'b0;
            fe_pend_q <= 1'b0;
          end
        end else begin
          sc_q <= sc_end ? '0 : sc_q + SCW'(1);
          if (sc_q == SC_S0) s0_q <= rxs_q;
          if (sc_q == SC_S1) s1_q <= rxs_q;

          case (state_q)
            S_START: begin
              // A false start wins over the bit-end transition when both
              // fall on the same tick (small OVERSAMPLE).
              if (vote_done && maj) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else if (sc_end) begin
                state_q   <= S_DATA;
                bit_idx_q <= '0;
              end
            end
            S_DATA: begin
              if (vote_done) shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
              if (sc_end) begin
                if (bit_idx_q == BIT_LAST) begin
                  state_q    <= (PARITY != 0) ? S_PARITY : S_STOP;
                  stop_idx_q <= 1'b0;
                end else begin
                  bit_idx_q <= bit_idx_q + BW'(1);
                end
              end
            end
            S_PARITY: begin
              if (vote_done) pe_pend_q <= par_bad;
              if (sc_end) begin
                state_q    <= S_STOP;
                stop_idx_q <= 1'b0;
              end
            end
            S_STOP: begin
              if (vote_done && (stop_idx_q == STOP_LAST)) begin
                // Commit at mid-bit so a back-to-back start is not missed.
                rx_data_q    <= shreg_q;
                parity_err_q <= pe_pend_q;
                frame_err_q  <= fe_pend_q | ~maj;
                rx_valid_q   <= 1'b1;
                if (rx_valid_q && !rx_ready) overrun_q <= 1'b1;
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                // A low last stop bit may be a break: require idle first.
                armed_q <= maj;
              end else begin
                if (vote_done && !maj) fe_pend_q <= 1'b1;
                if (sc_end) stop_idx_q <= 1'b1;
              end
            end
            default: begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (8N1, 7E1, 8N2) with DIV=4 and
// OVERSAMPLE=4, so one bit is 16 clk. Line transitions are driven one clk
// after a tick-aligned edge, which puts the vote samples mid-bit.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx_l  = 3'b111;
  logic [2:0] rdy   = 3'b000;
  logic [2:0] valid, pe, fe, ovr, bsy;
  logic [7:0] d0, d2;
  logic [6:0] d1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ovr_cnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (ovr[i]) ovr_cnt[i] = ovr_cnt[i] + 1;
  end

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(4),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .rx(rx_l[0]), .rx_data(d0), .rx_valid(valid[0]),
    .rx_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]),
    .overrun(ovr[0]), .busy(bsy[0]));

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(4),
                  .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
    .clk(clk), .rst(rst), .rx(rx_l[1]), .rx_data(d1), .rx_valid(valid[1]),
    .rx_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]),
    .overrun(ovr[1]), .busy(bsy[1]));

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(4),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .rx(rx_l[2]), .rx_data(d2), .rx_valid(valid[2]),
    .rx_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]),
    .overrun(ovr[2]), .busy(bsy[2]));

  function automatic logic [8:0] get_data(input int s);
    case (s)
      0:       return {1'b0, d0};
      1:       return {2'b00, d1};
      default: return {1'b0, d2};
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Land 1 clk after an edge whose index is 1 mod 4 (tick phase known).
  task automatic align();
    do step(1); while (cyc % 4 != 1);
  endtask

  // Send n line bits (LSB first). gbit: bit with a 1-clk mid-bit glitch.
  // rbit: bit during whose vote tick rx_ready is pulsed.
  task automatic send(input int s, input logic [31:0] bits, input int n,
                      input int gbit, input int rbit);
    align();
    for (int i = 0; i < n; i++) begin
      rx_l[s] = bits[i];
      if (i == gbit) begin
        step(8); rx_l[s] = ~bits[i]; step(1); rx_l[s] = bits[i]; step(7);
      end else if (i == rbit) begin
        step(14); rdy[s] = 1'b1; step(1); rdy[s] = 1'b0; step(1);
      end else begin
        step(16);
      end
    end
    rx_l[s] = 1'b1;
  endtask

  task automatic consume(input int s, input string nm);
    rdy[s] = 1'b1; step(1); rdy[s] = 1'b0;
    check({nm, "_consumed"}, 32'(valid[s]), 32'd0);
  endtask

  typedef struct {
    int         s;
    logic [31:0] bits;
    int         n;
    int         gbit;
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } vec_t;

  vec_t vt [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int o;
    vt[0] = '{0, 32'h34A, 10, -1, 9'h0A5, 1'b0, 1'b0}; // 8N1 0xA5
    vt[1] = '{0, 32'h34A, 10,  3, 9'h0A5, 1'b0, 1'b0}; // glitch on a 1 bit
    vt[2] = '{0, 32'h34A, 10,  2, 9'h0A5, 1'b0, 1'b0}; // glitch on a 0 bit
    vt[3] = '{0, 32'h078, 10, -1, 9'h03C, 1'b0, 1'b1}; // stop bit low
    vt[4] = '{1, 32'h3AA, 10, -1, 9'h055, 1'b1, 1'b0}; // 7E1 wrong parity
    vt[5] = '{1, 32'h2AA, 10, -1, 9'h055, 1'b0, 1'b0}; // 7E1 right parity
    vt[6] = '{1, 32'h30E, 10, -1, 9'h007, 1'b0, 1'b0}; // 7E1 odd count, par 1
    vt[7] = '{2, 32'h678, 11, -1, 9'h03C, 1'b0, 1'b0}; // 8N2 clean
    vt[8] = '{2, 32'h278, 11, -1, 9'h03C, 1'b0, 1'b1}; // second stop low
    vt[9] = '{2, 32'h478, 11, -1, 9'h03C, 1'b0, 1'b1}; // first stop low

    step(3);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst_valid%0d", s), 32'(valid[s]), 32'd0);
      check($sformatf("rst_data%0d", s), 32'(get_data(s)), 32'd0);
      check($sformatf("rst_busy%0d", s), 32'(bsy[s]), 32'd0);
      check($sformatf("rst_errs%0d", s), {29'd0, pe[s], fe[s], ovr[s]}, 32'd0);
    end
    rst = 1'b0;
    step(16);

    for (int i = 0; i < 10; i++) begin
      o = ovr_cnt[vt[i].s];
      send(vt[i].s, vt[i].bits, vt[i].n, vt[i].gbit, -1);
      check($sformatf("v%0d_valid", i), 32'(valid[vt[i].s]), 32'd1);
      check($sformatf("v%0d_data", i), 32'(get_data(vt[i].s)), 32'(vt[i].data));
      check($sformatf("v%0d_perr", i), 32'(pe[vt[i].s]), 32'(vt[i].pe));
      check($sformatf("v%0d_ferr", i), 32'(fe[vt[i].s]), 32'(vt[i].fe));
      check($sformatf("v%0d_ovr", i), 32'(ovr_cnt[vt[i].s] - o), 32'd0);
      check($sformatf("v%0d_busy", i), 32'(bsy[vt[i].s]), 32'd0);
      consume(vt[i].s, $sformatf("v%0d", i));
      step(8);
    end

    // Short low pulse on an idle line: false start.
    align();
    rx_l[0] = 1'b0; step(5);
    check("glitch_busy_hi", 32'(bsy[0]), 32'd1);
    step(3); rx_l[0] = 1'b1; step(24);
    check("glitch_busy_lo", 32'(bsy[0]), 32'd0);
    check("glitch_valid", 32'(valid[0]), 32'd0);

    // Back-to-back 0x11, 0x22 with no consumer: exactly one overrun.
    o = ovr_cnt[0];
    send(0, 32'h91222, 20, -1, -1);
    check("ovr_count", 32'(ovr_cnt[0] - o), 32'd1);
    check("ovr_data", 32'(get_data(0)), 32'h22);
    check("ovr_valid", 32'(valid[0]), 32'd1);
    consume(0, "ovr");
    step(8);

    // Same stream, consumer accepts frame 1 on frame 2's commit cycle.
    o = ovr_cnt[0];
    send(0, 32'h91222, 20, -1, 19);
    check("ovr_rdy_count", 32'(ovr_cnt[0] - o), 32'd0);
    check("ovr_rdy_data", 32'(get_data(0)), 32'h22);
    check("ovr_rdy_valid", 32'(valid[0]), 32'd1);
    consume(0, "ovr_rdy");
    step(8);

    // Break on the 8N2 receiver: one zero frame, then silence.
    o = ovr_cnt[2];
    align();
    rx_l[2] = 1'b0;
    step(320);
    check("brk_valid", 32'(valid[2]), 32'd1);
    check("brk_data", 32'(get_data(2)), 32'd0);
    check("brk_ferr", 32'(fe[2]), 32'd1);
    check("brk_ovr", 32'(ovr_cnt[2] - o), 32'd0);
    check("brk_busy", 32'(bsy[2]), 32'd0);
    rx_l[2] = 1'b1;
    consume(2, "brk");
    step(48);
    check("brk_after_valid", 32'(valid[2]), 32'd0);
    send(2, 32'h702, 11, -1, -1);
    check("brk_next_data", 32'(get_data(2)), 32'h81);
    check("brk_next_ferr", 32'(fe[2]), 32'd0);
    consume(2, "brk_next");

    // Reset in data bit 3 with the line low; a pending frame is dropped.
    send(0, 32'h34A, 10, -1, -1);
    align();
    rx_l[0] = 1'b0;
    step(72);
    check("rstmid_busy_before", 32'(bsy[0]), 32'd1);
    rst = 1'b1; step(2);
    check("rstmid_valid", 32'(valid[0]), 32'd0);
    check("rstmid_data", 32'(get_data(0)), 32'd0);
    check("rstmid_flags", {28'd0, pe[0], fe[0], ovr[0], bsy[0]}, 32'd0);
    rst = 1'b0;
    step(48);
    check("rstmid_low_busy", 32'(bsy[0]), 32'd0);
    check("rstmid_low_valid", 32'(valid[0]), 32'd0);
    rx_l[0] = 1'b1;
    step(32);
    send(0, 32'h2B4, 10, -1, -1);
    check("rstmid_new_valid", 32'(valid[0]), 32'd1);
    check("rstmid_new_data", 32'(get_data(0)), 32'h5A);
    consume(0, "rstmid_new");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
